// File: rtl/btn_event_pkg.sv
// Shared types for the button gesture classifier.
//   btn_state_t : gesture FSM states
//   btn_event_t : gesture event kinds (used by the classifier and by scoreboards)
package btn_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT_GAP,
    LONG_HELD,
    SECOND_HELD
  } btn_state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_SHORT,
    EV_LONG,
    EV_DOUBLE,
    EV_REPEAT
  } btn_event_t;

endpackage

// File: rtl/edge_detect.sv
// One-flop edge detector on an already-synchronous level.
// Ports:
//   clk, negated_reset : clock / async active-low reset
//   d                  : input level
//   rise, fall         : combinational edge strobes (d vs. previous-cycle d)
module edge_detect (
  input  logic clk,
  input  logic negated_reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // Previous-cycle copy of the level; cleared by reset so a held level re-fires rise.
  always_ff @(posedge clk or negedge negated_reset) begin
    if (!negated_reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into short / long / double press events,
// emitted as registered one-cycle pulses.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat pulses while long-held).
// Ports:
//   clk, negated_reset : clock / async active-low reset
//   btn_level          : debounced, clk-synchronous button level (1 = pressed)
//   short_press        : pulse, single short press completed
//   long_press         : pulse, hold reached LONG_CYCLES
//   double_press       : pulse, second press started inside the gap
//   repeat_press       : pulse every REPEAT_CYCLES while long-held (0 without macro)
//   busy               : gesture in progress (state != IDLE)
module button_event_classifier
  import btn_event_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned GAP_CYCLES    = 250,
  parameter int unsigned REPEAT_CYCLES = 100
) (
  input  logic clk,
  input  logic negated_reset,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic busy
);

  // Terminal counts; the counter restarts at 0 on every state entry.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_event_t       ev_d;
  logic             rise, fall;

  edge_detect u_edge (
    .clk           (clk),
    .negated_reset (negated_reset),
    .d             (btn_level),
    .rise          (rise),
    .fall          (fall)
  );

  // Next-state, counter and event decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_d    = EV_NONE;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Release beats the long threshold when both land together.
        if (fall) begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          cnt_d   = '0;
          ev_d    = EV_LONG;
        end
      end
      WAIT_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A second press on the timeout cycle still counts as double.
        if (rise) begin
          state_d = SECOND_HELD;
          cnt_d   = '0;
          ev_d    = EV_DOUBLE;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ev_d    = EV_SHORT;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef BTN_REPEAT_EN
        // Counter doubles as the auto-repeat period timer.
        else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
          cnt_d = '0;
          ev_d  = EV_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      SECOND_HELD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge negated_reset) begin
    if (!negated_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= (ev_d == EV_SHORT);
      long_press   <= (ev_d == EV_LONG);
      double_press <= (ev_d == EV_DOUBLE);
      busy         <= (state_d != IDLE);
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk or negedge negated_reset) begin
    if (!negated_reset) begin
      repeat_press <= 1'b0;
    end else begin
      repeat_press <= (ev_d == EV_REPEAT);
    end
  end
`else
  assign repeat_press = 1'b0;

  logic unused_repeat_cycles_c;
  assign unused_repeat_cycles_c = (REPEAT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_button_event_classifier.sv
// Randomized self-checking bench for button_event_classifier against a
// timestamp-based gesture model.
module tb_button_event_classifier;
  import btn_event_pkg::*;

  localparam int unsigned CNT_W         = 8;
  localparam int unsigned LONG_CYCLES   = 8;
  localparam int unsigned GAP_CYCLES    = 4;
  localparam int unsigned REPEAT_CYCLES = 3;

  // Gesture phases of the reference model.
  localparam int G_NONE   = 0;
  localparam int G_FIRST  = 1;
  localparam int G_GAP    = 2;
  localparam int G_LONG   = 3;
  localparam int G_SECOND = 4;

  logic clk = 1'b0;
  logic negated_reset;
  logic btn_level;
  logic short_press, long_press, double_press, repeat_press, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: phase, timestamp of the last relevant edge, cycle index.
  int         g      = G_NONE;
  int         t_mark = 0;
  int         n      = 0;
  logic       prev   = 1'b0;
  btn_event_t exp_ev = EV_NONE;
  logic       exp_busy = 1'b0;

  always #5 clk = ~clk;

  button_event_classifier #(
    .CNT_W         (CNT_W),
    .LONG_CYCLES   (LONG_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .clk           (clk),
    .negated_reset (negated_reset),
    .btn_level     (btn_level),
    .short_press   (short_press),
    .long_press    (long_press),
    .double_press  (double_press),
    .repeat_press  (repeat_press),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] pulses_of(input btn_event_t e);
    case (e)
      EV_SHORT:  return 4'b1000;
      EV_LONG:   return 4'b0100;
      EV_DOUBLE: return 4'b0010;
      EV_REPEAT: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  task automatic check_outputs(input string where);
    logic [3:0] p;
    p = {short_press, long_press, double_press, repeat_press};
    check_eq({where, ".pulses"}, 32'(p), 32'(pulses_of(exp_ev)));
    check_eq({where, ".busy"}, 32'(busy), 32'(exp_busy));
    check_eq({where, ".onehot"}, 32'($countones(p) <= 1), 32'd1);
  endtask

  // Advance the gesture model by one input cycle; produces expectations for the next cycle.
  task automatic model_step(input logic lvl);
    logic       rise, fall;
    btn_event_t ev;
    rise = lvl & ~prev;
    fall = ~lvl & prev;
    prev = lvl;
    ev   = EV_NONE;
    case (g)
      G_NONE: if (rise) begin
        g      = G_FIRST;
        t_mark = n;
      end
      G_FIRST: if (fall) begin
        g      = G_GAP;
        t_mark = n;
      end else if (n - t_mark == int'(LONG_CYCLES) - 1) begin
        g      = G_LONG;
        ev     = EV_LONG;
        t_mark = n + 1;
      end
      G_GAP: if (rise) begin
        g  = G_SECOND;
        ev = EV_DOUBLE;
      end else if (n - t_mark == int'(GAP_CYCLES)) begin
        g  = G_NONE;
        ev = EV_SHORT;
      end
      G_LONG: if (fall) begin
        g = G_NONE;
      end
`ifdef BTN_REPEAT_EN
      else if ((n + 1 - t_mark) % int'(REPEAT_CYCLES) == 0) begin
        ev = EV_REPEAT;
      end
`endif
      G_SECOND: if (fall) begin
        g = G_NONE;
      end
      default: g = G_NONE;
    endcase
    exp_ev   = ev;
    exp_busy = (g != G_NONE);
    n++;
  endtask

  // Called at a negedge: check current outputs, drive one cycle of input.
  task automatic step(input logic lvl, input string where);
    check_outputs(where);
    btn_level = lvl;
    model_step(lvl);
    @(negedge clk);
  endtask

  task automatic hold(input logic lvl, input int cycles, input string where);
    for (int i = 0; i < cycles; i++) step(lvl, where);
  endtask

  // Called at a negedge: asynchronous reset with optional input toggling; returns at a negedge.
  task automatic do_reset(input int cycles, input logic toggle, input string where);
    negated_reset = 1'b0;
    exp_ev   = EV_NONE;
    exp_busy = 1'b0;
    #1;
    check_outputs(where);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (toggle) btn_level = 1'($urandom);
      #1;
      check_outputs(where);
    end
    @(negedge clk);
    negated_reset = 1'b1;
    g    = G_NONE;
    prev = 1'b0;
  endtask

  initial begin
    negated_reset = 1'b1;
    btn_level     = 1'b0;
    @(negedge clk);

    do_reset(5, 1'b1, "reset");
    hold(1'b0, 3, "idle");

    hold(1'b1, 3, "short");
    hold(1'b0, 8, "short");

    hold(1'b1, 20, "long");
    hold(1'b0, 4, "long");

    hold(1'b1, 2, "double");
    hold(1'b0, 2, "double");
    hold(1'b1, 2, "double");
    hold(1'b0, 8, "double");

    hold(1'b1, 2, "gap_edge");
    hold(1'b0, GAP_CYCLES, "gap_edge");
    hold(1'b1, 2, "gap_edge");
    hold(1'b0, 8, "gap_edge");

    hold(1'b1, 2, "gap_late");
    hold(1'b0, GAP_CYCLES + 1, "gap_late");
    hold(1'b1, 2, "gap_late");
    hold(1'b0, 8, "gap_late");

    hold(1'b1, 6, "mid_reset");
    btn_level = 1'b1;
    do_reset(2, 1'b0, "mid_reset");
    hold(1'b1, 12, "mid_reset");
    hold(1'b0, 8, "mid_reset");

    for (int k = 0; k < 60; k++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        hold(1'b1, int'($urandom_range(1, 9)), "rand_rst");
        do_reset(int'($urandom_range(0, 2)), 1'b1, "rand_rst");
      end else begin
        hold(1'b1, int'($urandom_range(1, 14)), "rand");
        hold(1'b0, int'($urandom_range(1, 7)), "rand");
      end
    end
    hold(1'b0, 10, "drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
